// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter shared types: FSM states, requester ids, ALU opcodes
// and the opcode legality helper used by the arbiter.
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_EEE  = 4'hF;

    function automatic logic op_legal(input logic [3:0] f);
        case (f)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU:
                op_legal = 1'b1;
            default:
                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_grant2.sv
// alu_rr_grant2: combinational two-way round-robin picker.
// Ports: valid[1:0], last_grant in; grant_id, grant_valid out.
module alu_rr_grant2
    import alu_share_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = ID0;
        unique case (1'b1)
            (valid == 2'b11): grant_id = ~last_grant;
            (valid == 2'b10): grant_id = ID1;
            default:          grant_id = ID0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between two requesters.
// Ports: clk, rst (sync, active-high); req0_*/req1_* valid/ready request
// channels; alu_* drive/return of the combinational ALU; rsp_* registered
// response channel. ALU_ARB_STATS_EN adds grant_cnt0/1 and conflict_cnt.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_func,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_func,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [3:0]            alu_func,
    output logic [DATA_WIDTH-1:0] alu_in_a,
    output logic [DATA_WIDTH-1:0] alu_in_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_check,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_check,
    output logic                  rsp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

    state_t                state;
    logic                  last_grant;
    logic [3:0]            l_func;
    logic [DATA_WIDTH-1:0] l_a;
    logic [DATA_WIDTH-1:0] l_b;
    logic                  grant_id;
    logic                  grant_valid;
    logic                  grant;

    alu_rr_grant2 u_pick (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Gate with rst so nothing handshakes during a reset cycle.
    assign grant      = (state == IDLE) && grant_valid && !rst;
    assign req0_ready = grant && (grant_id == ID0);
    assign req1_ready = grant && (grant_id == ID1);
    assign rsp_valid  = (state == RESP) && !rst;

    // Park the ALU inputs outside EXEC to avoid toggling on stale data.
    always_comb begin
        alu_func = OP_ADD;
        alu_in_a = '0;
        alu_in_b = '0;
        if (state == EXEC) begin
            alu_func = l_func;
            alu_in_a = l_a;
            alu_in_b = l_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID1;
            l_func     <= OP_ADD;
            l_a        <= '0;
            l_b        <= '0;
            rsp_id     <= ID0;
            rsp_data   <= '0;
            rsp_check  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        l_func     <= grant_id ? req1_func : req0_func;
                        l_a        <= grant_id ? req1_a : req0_a;
                        l_b        <= grant_id ? req1_b : req0_b;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // last_grant still names the owner of this op.
                    rsp_id <= last_grant;
                    if (op_legal(l_func)) begin
                        rsp_data  <= alu_result;
                        rsp_check <= alu_check;
                        rsp_err   <= 1'b0;
                    end else begin
                        rsp_data  <= '0;
                        rsp_check <= 1'b0;
                        rsp_err   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else if (grant) begin
            if (grant_id == ID0 && !(&grant_cnt0))
                grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
            if (grant_id == ID1 && !(&grant_cnt1))
                grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
            if (req0_valid && req1_valid && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
